// File: rtl/icache_pkg.sv
// icache_pkg: shared types and width helpers for the set-associative
// instruction cache.
//   state_t      - miss/refill FSM states
//   off_w/idx_w  - offset and index field widths of a byte address
//   tag_w        - remaining tag width
//   byte_w       - byte-in-word bits ignored on fetch addresses
//   word_index   - word-in-line index of a byte address
//   line_word    - extract one word from a refill line
package icache_pkg;

  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT} state_t;

  // Upper bounds for the generic helpers below.
  localparam int unsigned MAX_ADDR_W = 128;
  localparam int unsigned MAX_LINE_W = 4096;
  localparam int unsigned MAX_WORD_W = 128;

  function automatic int unsigned off_w(input int unsigned line_words,
                                        input int unsigned word_w);
    return $clog2(line_words * word_w / 8);
  endfunction

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w,
                                        input int unsigned line_words,
                                        input int unsigned word_w,
                                        input int unsigned sets);
    return addr_w - off_w(line_words, word_w) - idx_w(sets);
  endfunction

  function automatic int unsigned byte_w(input int unsigned word_w);
    return $clog2(word_w / 8);
  endfunction

  function automatic logic [31:0] word_index(input logic [MAX_ADDR_W-1:0] addr,
                                             input int unsigned bw,
                                             input int unsigned line_words);
    return 32'((addr >> bw) & MAX_ADDR_W'(line_words - 1));
  endfunction

  function automatic logic [MAX_WORD_W-1:0] line_word(input logic [MAX_LINE_W-1:0] line,
                                                      input logic [31:0] word,
                                                      input int unsigned word_w);
    return MAX_WORD_W'(line >> (word * word_w));
  endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// icache_victim_sel: per-set replacement state and victim choice.
//   clock, reset   - clock, async active-high reset (state cleared to 0)
//   lookup_idx     - set being refilled
//   lookup_valid   - valid bits of that set
//   hit, fill      - update strobes (never both in one cycle)
//   upd_idx/way    - set and way touched by the hit or fill
//   victim         - way to refill: lowest invalid way, else LRU/round-robin
module icache_victim_sel
  import icache_pkg::*;
#(
  parameter int unsigned SETS  = 8,
  parameter int unsigned WAYS  = 2,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned WAY_W = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] lookup_idx,
  input  logic [WAYS-1:0]  lookup_valid,
  input  logic             hit,
  input  logic             fill,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [WAY_W-1:0] upd_way,
  output logic [WAY_W-1:0] victim
);

  logic [WAY_W-1:0] repl_way;

  generate
    if (WAYS == 2) begin : g_lru
      // One bit per set naming the least recently used way.
      logic lru_q [SETS];
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int unsigned s = 0; s < SETS; s++) lru_q[s] <= 1'b0;
        end else if (hit || fill) begin
          lru_q[upd_idx] <= ~upd_way[0];
        end
      end
      always_comb repl_way = WAY_W'(lru_q[lookup_idx]);
    end else if (WAYS == 4) begin : g_rr
      logic [1:0] rr_q [SETS];
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int unsigned s = 0; s < SETS; s++) rr_q[s] <= 2'd0;
        end else if (fill) begin
          rr_q[upd_idx] <= rr_q[upd_idx] + 2'd1;
        end
      end
      always_comb repl_way = WAY_W'(rr_q[lookup_idx]);
    end else begin : g_dm
      always_comb repl_way = '0;
    end
  endgenerate

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    victim = repl_way;
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (!lookup_valid[w-1]) victim = WAY_W'(w - 1);
    end
  end

endmodule

// File: rtl/icache_sa.sv
// icache_sa: set-associative instruction cache between fetch and memory.
//   clock, reset          - clock, async active-high reset
//   req_valid/addr/ready  - fetch request handshake (byte address)
//   resp_valid/instr      - one-cycle response pulse, instr held between pulses
//   flush                 - invalidate all lines (deferred while a miss is open)
//   mem_req_valid/addr/ready - line refill request (line-aligned address)
//   mem_resp_valid/data   - refill line, word 0 in the LSBs
module icache_sa
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SETS       = 8,
  parameter int unsigned WAYS       = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic [ADDR_W-1:0]            req_addr,
  output logic                         req_ready,
  output logic                         resp_valid,
  output logic [WORD_W-1:0]            resp_instr,
  input  logic                         flush,
  output logic                         mem_req_valid,
  output logic [ADDR_W-1:0]            mem_req_addr,
  input  logic                         mem_req_ready,
  input  logic                         mem_resp_valid,
  input  logic [LINE_WORDS*WORD_W-1:0] mem_resp_data
);

  localparam int unsigned OFF_W      = off_w(LINE_WORDS, WORD_W);
  localparam int unsigned IDX_W      = idx_w(SETS);
  localparam int unsigned TAG_W      = tag_w(ADDR_W, LINE_WORDS, WORD_W, SETS);
  localparam int unsigned BYTE_W     = byte_w(WORD_W);
  localparam int unsigned LINE_W     = LINE_WORDS * WORD_W;
  localparam int unsigned LINE_BYTES = LINE_W / 8;
  localparam int unsigned WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_t            state;
  logic [WAYS-1:0]   valid_q [SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [LINE_W-1:0] data_q  [WAYS][SETS];
  logic              flush_pend;

  logic [TAG_W-1:0]  miss_tag;
  logic [IDX_W-1:0]  miss_idx;
  logic [31:0]       miss_word;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [31:0]       req_word;
  logic              accept;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [LINE_W-1:0] hit_line;
  logic              fill;
  logic [WAY_W-1:0]  victim;
  logic [IDX_W-1:0]  upd_idx;
  logic [WAY_W-1:0]  upd_way;

  always_comb begin
    req_tag  = req_addr[ADDR_W-1 -: TAG_W];
    req_idx  = req_addr[OFF_W +: IDX_W];
    req_word = word_index(MAX_ADDR_W'(req_addr), BYTE_W, LINE_WORDS);
  end

  // Gated by reset so the fetch stage sees not-ready during reset.
  always_comb req_ready = (state == IDLE) && !flush && !flush_pend && !reset;
  always_comb accept    = req_valid && req_ready;
  always_comb fill      = (state == MISS_WAIT) && mem_resp_valid;

  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_line = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag)) begin
        hit      = 1'b1;
        hit_way  = WAY_W'(w);
        hit_line = data_q[w][req_idx];
      end
    end
  end

  always_comb begin
    upd_idx = fill ? miss_idx : req_idx;
    upd_way = fill ? victim : hit_way;
  end

  icache_victim_sel #(
    .SETS  (SETS),
    .WAYS  (WAYS),
    .IDX_W (IDX_W),
    .WAY_W (WAY_W)
  ) u_victim (
    .clock        (clock),
    .reset        (reset),
    .lookup_idx   (miss_idx),
    .lookup_valid (valid_q[miss_idx]),
    .hit          (accept && hit),
    .fill         (fill),
    .upd_idx      (upd_idx),
    .upd_way      (upd_way),
    .victim       (victim)
  );

  // Tag and line storage carry no reset; valid bits gate their use.
  always_ff @(posedge clock) begin
    if (fill) begin
      tag_q[victim][miss_idx]  <= miss_tag;
      data_q[victim][miss_idx] <= mem_resp_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      for (int unsigned s = 0; s < SETS; s++) valid_q[s] <= '0;
      flush_pend    <= 1'b0;
      resp_valid    <= 1'b0;
      resp_instr    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      miss_tag      <= '0;
      miss_idx      <= '0;
      miss_word     <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (flush || flush_pend) begin
            for (int unsigned s = 0; s < SETS; s++) valid_q[s] <= '0;
            flush_pend <= 1'b0;
          end else if (accept) begin
            if (hit) begin
              resp_valid <= 1'b1;
              resp_instr <= WORD_W'(line_word(MAX_LINE_W'(hit_line), req_word, WORD_W));
            end else begin
              miss_tag      <= req_tag;
              miss_idx      <= req_idx;
              miss_word     <= req_word;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= req_addr & ~ADDR_W'(LINE_BYTES - 1);
              state         <= MISS_REQ;
            end
          end
        end
        MISS_REQ: begin
          if (flush) flush_pend <= 1'b1;
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (flush) flush_pend <= 1'b1;
          if (mem_resp_valid) begin
            valid_q[miss_idx][victim] <= 1'b1;
            resp_valid <= 1'b1;
            resp_instr <= WORD_W'(line_word(MAX_LINE_W'(mem_resp_data), miss_word, WORD_W));
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: directed scenarios for icache_sa at default parameters.
module tb_icache_sa;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic [63:0]  req_addr = '0;
  logic         req_ready;
  logic         resp_valid;
  logic [31:0]  resp_instr;
  logic         flush = 1'b0;
  logic         mem_req_valid;
  logic [63:0]  mem_req_addr;
  logic         mem_req_ready = 1'b0;
  logic         mem_resp_valid = 1'b0;
  logic [127:0] mem_resp_data = '0;

  int compared = 0;
  int mismatched = 0;

  localparam logic [127:0] LA = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [127:0] LB = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
  localparam logic [127:0] LC = {32'hC3, 32'hC2, 32'hC1, 32'hC0};

  icache_sa dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_instr     (resp_instr),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic apply_reset();
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // One complete miss: request, accept memory request, return line.
  task automatic refill(input logic [63:0] a, input logic [127:0] line,
                        output logic rq_v, output logic [63:0] rq_a,
                        output logic rs_v, output logic [31:0] rs_i);
    req_valid = 1'b1; req_addr = a;
    @(negedge clock);
    req_valid = 1'b0;
    rq_v = mem_req_valid; rq_a = mem_req_addr;
    mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = line;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    rs_v = resp_valid; rs_i = resp_instr;
  endtask

  task automatic lookup(input logic [63:0] a, output logic rs_v,
                        output logic [31:0] rs_i, output logic missed);
    req_valid = 1'b1; req_addr = a;
    @(negedge clock);
    req_valid = 1'b0;
    rs_v = resp_valid; rs_i = resp_instr; missed = mem_req_valid;
  endtask

  task automatic test_reset();
    @(negedge clock);
    compared++; if (req_ready !== 1'b0) begin mismatched++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    compared++; if (resp_valid !== 1'b0) begin mismatched++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    compared++; if (resp_instr !== 32'h0) begin mismatched++; $display("FAIL rst_instr: got %h want 0", resp_instr); end
    compared++; if (mem_req_valid !== 1'b0) begin mismatched++; $display("FAIL rst_mem_valid: got %b want 0", mem_req_valid); end
    compared++; if (mem_req_addr !== 64'h0) begin mismatched++; $display("FAIL rst_mem_addr: got %h want 0", mem_req_addr); end
    reset = 1'b0;
    #1;
    compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
    @(negedge clock);
  endtask

  task automatic test_cold_miss();
    logic rq_v, rs_v;
    logic [63:0] rq_a;
    logic [31:0] rs_i;
    apply_reset();
    refill(64'h104, LA, rq_v, rq_a, rs_v, rs_i);
    compared++; if (rq_v !== 1'b1) begin mismatched++; $display("FAIL cold_mem_valid: got %b want 1", rq_v); end
    compared++; if (rq_a !== 64'h100) begin mismatched++; $display("FAIL cold_mem_addr: got %h want 100", rq_a); end
    compared++; if (rs_v !== 1'b1) begin mismatched++; $display("FAIL cold_resp_valid: got %b want 1", rs_v); end
    compared++; if (rs_i !== 32'hA1) begin mismatched++; $display("FAIL cold_instr: got %h want a1", rs_i); end
    compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL cold_ready_after: got %b want 1", req_ready); end
  endtask

  // Relies on the line loaded by test_cold_miss.
  task automatic test_back_to_back();
    logic [63:0] addrs [3];
    logic [31:0] exp   [3];
    addrs[0] = 64'h10C; addrs[1] = 64'h100; addrs[2] = 64'h108;
    exp[0] = 32'hA3; exp[1] = 32'hA0; exp[2] = 32'hA2;
    req_valid = 1'b1; req_addr = addrs[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      compared++; if (resp_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, resp_valid); end
      compared++; if (resp_instr !== exp[i]) begin mismatched++; $display("FAIL b2b_instr[%0d]: got %h want %h", i, resp_instr, exp[i]); end
      compared++; if (mem_req_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_mem_valid[%0d]: got %b want 0", i, mem_req_valid); end
      if (i < 2) req_addr = addrs[i+1];
      else req_valid = 1'b0;
    end
    @(negedge clock);
    compared++; if (resp_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_pulse_end: got %b want 0", resp_valid); end
    compared++; if (resp_instr !== 32'hA2) begin mismatched++; $display("FAIL b2b_instr_hold: got %h want a2", resp_instr); end
  endtask

  task automatic test_lru_evict();
    logic rq_v, rs_v, missed;
    logic [63:0] rq_a;
    logic [31:0] rs_i;
    apply_reset();
    refill(64'h000, LB, rq_v, rq_a, rs_v, rs_i);
    compared++; if (rs_i !== 32'hB0) begin mismatched++; $display("FAIL lru_fill0: got %h want b0", rs_i); end
    refill(64'h084, LC, rq_v, rq_a, rs_v, rs_i);
    compared++; if (rs_i !== 32'hC1) begin mismatched++; $display("FAIL lru_fill1: got %h want c1", rs_i); end
    compared++; if (rq_a !== 64'h080) begin mismatched++; $display("FAIL lru_fill1_addr: got %h want 80", rq_a); end
    lookup(64'h000, rs_v, rs_i, missed);
    compared++; if ({rs_v, missed, rs_i} !== {1'b1, 1'b0, 32'hB0}) begin mismatched++; $display("FAIL lru_hit0: got v=%b miss=%b %h want v=1 miss=0 b0", rs_v, missed, rs_i); end
    refill(64'h10C, LA, rq_v, rq_a, rs_v, rs_i);
    compared++; if (rq_v !== 1'b1) begin mismatched++; $display("FAIL lru_evict_miss: got %b want 1", rq_v); end
    compared++; if (rs_i !== 32'hA3) begin mismatched++; $display("FAIL lru_evict_instr: got %h want a3", rs_i); end
    lookup(64'h008, rs_v, rs_i, missed);
    compared++; if ({rs_v, missed, rs_i} !== {1'b1, 1'b0, 32'hB2}) begin mismatched++; $display("FAIL lru_keep0: got v=%b miss=%b %h want v=1 miss=0 b2", rs_v, missed, rs_i); end
    lookup(64'h080, rs_v, rs_i, missed);
    compared++; if ({rs_v, missed} !== 2'b01) begin mismatched++; $display("FAIL lru_evicted80: got v=%b miss=%b want v=0 miss=1", rs_v, missed); end
  endtask

  task automatic test_flush();
    logic rq_v, rs_v, missed;
    logic [63:0] rq_a;
    logic [31:0] rs_i;
    apply_reset();
    refill(64'h100, LA, rq_v, rq_a, rs_v, rs_i);
    lookup(64'h104, rs_v, rs_i, missed);
    compared++; if ({rs_v, missed, rs_i} !== {1'b1, 1'b0, 32'hA1}) begin mismatched++; $display("FAIL flush_prehit: got v=%b miss=%b %h want v=1 miss=0 a1", rs_v, missed, rs_i); end
    flush = 1'b1; req_valid = 1'b1; req_addr = 64'h100;
    #1;
    compared++; if (req_ready !== 1'b0) begin mismatched++; $display("FAIL flush_ready: got %b want 0", req_ready); end
    @(negedge clock);
    flush = 1'b0; req_valid = 1'b0;
    compared++; if ({resp_valid, mem_req_valid} !== 2'b00) begin mismatched++; $display("FAIL flush_no_accept: got v=%b mreq=%b want 00", resp_valid, mem_req_valid); end
    lookup(64'h100, rs_v, rs_i, missed);
    compared++; if ({rs_v, missed} !== 2'b01) begin mismatched++; $display("FAIL flush_miss: got v=%b miss=%b want v=0 miss=1", rs_v, missed); end
  endtask

  task automatic test_flush_pending();
    logic rs_v, missed;
    logic [31:0] rs_i;
    apply_reset();
    req_valid = 1'b1; req_addr = 64'h104;
    @(negedge clock);
    req_valid = 1'b0; mem_req_ready = 1'b1; flush = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0; flush = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = LA;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    compared++; if ({resp_valid, resp_instr} !== {1'b1, 32'hA1}) begin mismatched++; $display("FAIL fpend_resp: got v=%b %h want v=1 a1", resp_valid, resp_instr); end
    compared++; if (req_ready !== 1'b0) begin mismatched++; $display("FAIL fpend_ready_low: got %b want 0", req_ready); end
    @(negedge clock);
    compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL fpend_ready_back: got %b want 1", req_ready); end
    lookup(64'h104, rs_v, rs_i, missed);
    compared++; if ({rs_v, missed} !== 2'b01) begin mismatched++; $display("FAIL fpend_line_gone: got v=%b miss=%b want v=0 miss=1", rs_v, missed); end
  endtask

  task automatic test_backpressure_reset();
    logic rs_v, missed;
    logic [31:0] rs_i;
    apply_reset();
    req_valid = 1'b1; req_addr = 64'h208;
    @(negedge clock);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      compared++; if ({mem_req_valid, req_ready, mem_req_addr} !== {1'b1, 1'b0, 64'h200}) begin mismatched++; $display("FAIL bp_hold[%0d]: got v=%b rdy=%b %h want v=1 rdy=0 200", i, mem_req_valid, req_ready, mem_req_addr); end
      @(negedge clock);
    end
    // Reset while the request is still outstanding.
    reset = 1'b1;
    #1;
    compared++; if ({mem_req_valid, req_ready} !== 2'b00) begin mismatched++; $display("FAIL rst_in_req: got v=%b rdy=%b want 00", mem_req_valid, req_ready); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_addr = 64'h208;
    @(negedge clock);
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    reset = 1'b1;
    #1;
    compared++; if (mem_req_valid !== 1'b0) begin mismatched++; $display("FAIL rst_in_wait: got %b want 0", mem_req_valid); end
    @(negedge clock);
    reset = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = LA;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    compared++; if (resp_valid !== 1'b0) begin mismatched++; $display("FAIL rst_stale_resp: got %b want 0", resp_valid); end
    lookup(64'h208, rs_v, rs_i, missed);
    compared++; if ({rs_v, missed} !== 2'b01) begin mismatched++; $display("FAIL rst_no_fill: got v=%b miss=%b want v=0 miss=1", rs_v, missed); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_lru_evict();
    test_flush();
    test_flush_pending();
    test_backpressure_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised set-associative instruction cache sitting between the fetch stage and the instruction memory port. It generalises the direct-mapped line store in word width, line size, set count and associativity. It adds a valid/ready request handshake, an autonomous miss/refill state machine driving a memory line-request port, per-set victim selection, and a whole-cache flush. Hits return one cycle after acceptance; misses stall the fetch stage until the line is refilled.

## Interface
Parameters:
- ADDR_W, 64: byte-address width.
- WORD_W, 32: instruction width; WORD_W/8 bytes per word.
- LINE_WORDS, 4: words per line, power of 2.
- SETS, 8: number of sets, power of 2.
- WAYS, 2: associativity, one of 1, 2, 4.

Ports. One clock; reset is asynchronous and active-high.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_addr  in  ADDR_W  fetch byte address; low log2(WORD_W/8) bits ignored.
- req_ready  out  1  cache accepts a request this cycle.
- resp_valid  out  1  resp_instr valid, one-cycle pulse.
- resp_instr  out  WORD_W  fetched instruction.
- flush  in  1  invalidate all lines.
- mem_req_valid  out  1  line refill request.
- mem_req_addr  out  ADDR_W  line-aligned refill address; offset bits are 0.
- mem_req_ready  in  1  memory accepts refill request.
- mem_resp_valid  in  1  refill line present, one-cycle pulse.
- mem_resp_data  in  LINE_WORDS*WORD_W  refill line; word 0 is in the LSBs.

## Operation
- Address split: OFF = log2(LINE_WORDS*WORD_W/8) offset bits, then IDX = log2(SETS) index bits, then tag = the remaining ADDR_W-OFF-IDX bits. Defaults: offset [3:0], index [6:4], tag [63:7].
- Per way and set: valid bit, tag, line. Only valid bits, victim state, FSM and outputs are reset. Tag and data arrays are not reset.
- States:
  - IDLE: req_ready = !flush. On accept (req_valid & req_ready), all ways of the indexed set are compared combinationally.
    - Hit: register the selected word, pulse resp_valid next cycle, update victim state, stay IDLE. Back-to-back hits sustain one per cycle.
    - Miss: latch the address, go to MISS_REQ.
  - MISS_REQ: mem_req_valid = 1, with mem_req_addr stable until mem_req_ready. Then go to MISS_WAIT.
  - MISS_WAIT: on mem_resp_valid, write the line into the victim way, set valid, write the tag and update victim state. Next cycle, pulse resp_valid with the requested word taken from mem_resp_data, and go to IDLE.
- Victim selection:
  - Lowest-index invalid way first.
  - Otherwise, WAYS=2 uses a 1-bit LRU per set, updated on hit and on fill, pointing at the other way.
  - WAYS=4 uses a 2-bit per-set round-robin pointer, advanced on each fill only.
  - WAYS=1 is trivial.
- Flush:
  - In IDLE, all valid bits clear at the next edge. A simultaneous req_valid is not accepted (req_ready=0).
  - Asserted outside IDLE, flush sets a pending flag. The in-flight miss completes and responds, then all lines are invalidated on the first IDLE cycle, including the just-filled line. req_ready=0 in that cycle.
- mem_resp_valid outside MISS_WAIT is ignored.
- Word select within the line: address bits [OFF-1 : log2(WORD_W/8)].

## Timing
- Reset values: req_ready=0 while reset is asserted, then 1 from the first cycle after release (IDLE). resp_valid=0, resp_instr=0, mem_req_valid=0, mem_req_addr=0. All valid bits 0, victim state 0, flush pending 0.
- Reset mid-miss: the FSM returns to IDLE and mem_req_valid drops asynchronously. A later mem_resp_valid is ignored and no line is written.
- Hit latency: resp_valid in cycle N+1 for acceptance in cycle N.
- Miss latency: acceptance in cycle N, mem_req_valid from N+1. With mem_req_ready in N+1 and mem_resp_valid in cycle M ≥ N+2, resp_valid is in M+1 and req_ready is high again in M+1.
- req_ready is 0 in MISS_REQ and MISS_WAIT.
- resp_instr holds its value between pulses.

## Structure
- Package icache_pkg:
  - state enum {IDLE, MISS_REQ, MISS_WAIT};
  - functions deriving OFF, IDX and tag widths from the parameters;
  - a line-word-select helper.
- One sub-module: icache_victim_sel (per-set LRU/round-robin state, invalid-way priority, victim way output, hit/fill update inputs).
- Arrays use plain registers; no memory macros.

## Test plan
All scenarios use default parameters.
- Cold miss: after reset, request 0x104. Expect mem_req_addr=0x100. Return a line with words {0xA3,0xA2,0xA1,0xA0} (word 0 = 0xA0). Expect resp_instr=0xA1 one cycle after mem_resp_valid.
- Hit: then request 0x10C, 0x100, 0x108 back-to-back. Expect resp_valid on 3 consecutive cycles with 0xA3, 0xA0, 0xA2, and mem_req_valid never asserted.
- LRU eviction in set 0:
  - Fill 0x000 and 0x080 (both index 0), then access 0x000 (hit).
  - Request 0x100: it misses and evicts the 0x080 line.
  - Then 0x000 hits and 0x080 misses.
- Flush: flush together with req_valid for 0x100 in IDLE. Expect req_ready=0 that cycle; the next request to 0x100 misses.
- Backpressure and reset:
  - Hold mem_req_ready=0 for 5 cycles. Expect mem_req_valid=1 and mem_req_addr stable.
  - Assert reset in MISS_WAIT. Expect mem_req_valid=0 immediately; a following mem_resp_valid produces no resp_valid and the address still misses.
